i_memory_fetch: RTL and testbench
=================================

// Module: i_memory_fetch
// PURPOSE
//  Parametrised instruction memory: N-entry byte-wide array with a multi-byte fetch engine.
//  Loader writes one byte per cycle; CPU front-end requests an instruction address and
//  receives FETCH_BYTES consecutive bytes assembled into one instruction word.
//  Sits between the test-bench/boot loader and the CPU fetch stage.
// PARAMETERS
//  DATA_WIDTH   8   bits per memory entry
//  ADDR_WIDTH   10  address bits; depth = 1<<ADDR_WIDTH
//  FETCH_BYTES  2   entries assembled per fetch (>=1)
//  BIG_ENDIAN   1   1: byte at base addr -> MSBs of instr_out; 0: -> LSBs
// PORTS
//  clk          in   1                      system clock, posedge
//  rst_n        in   1                      async active-low reset
//  wr_en        in   1                      write strobe (loader)
//  wr_addr      in   ADDR_WIDTH             write address
//  wr_data      in   DATA_WIDTH             write data
//  fetch_req    in   1                      fetch request, sampled when fetch_rdy=1
//  fetch_addr   in   ADDR_WIDTH             base address of fetch
//  fetch_rdy    out  1                      engine idle, request accepted this cycle
//  instr_valid  out  1                      instr_out holds a complete word
//  instr_ack    in   1                      consumer takes instr_out
//  instr_out    out  DATA_WIDTH*FETCH_BYTES assembled instruction
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low (clk, rst_n). On rst_n=0:
//   state=IDLE, fetch_rdy=1, instr_valid=0, instr_out=0, counters=0. Array NOT cleared.
//  Single-port array, sync read: read data registered at clk edge, usable next cycle.
//  Write always has priority: wr_en=1 writes array at edge in any state; no read that cycle.
//  FSM: IDLE -> READ on fetch_req&fetch_rdy (latch base, issue_cnt=0, cap_cnt=0).
//   READ: each cycle with wr_en=0 and issue_cnt<FETCH_BYTES issues read of
//   (base+issue_cnt) mod depth; each registered byte is placed into its slot, cap_cnt++.
//   READ -> DONE when cap_cnt reaches FETCH_BYTES; instr_valid=1 in DONE.
//   DONE: instr_out and instr_valid held stable until instr_ack=1 at an edge -> IDLE.
//   instr_ack outside DONE ignored; fetch_req outside IDLE ignored (not queued).
//  Latency (no writes): instr_valid rises FETCH_BYTES+1 cycles after accept edge;
//   each wr_en cycle during READ adds exactly one cycle.
//  Coherence: write to a not-yet-read byte of the active fetch is seen by the fetch;
//   write to an already-captured byte, or during DONE, does not alter instr_out.
//  Wrap: base+k computed in ADDR_WIDTH bits; depth-1 followed by 0.
//  Slot k (0=base): BIG_ENDIAN=1 -> bits [(FETCH_BYTES-k)*DW-1 -: DW]; else [(k+1)*DW-1 -: DW].
//  Reset mid-fetch: aborts immediately, outputs to reset values, partial word discarded.
// STRUCTURE
//  Shared header DEFINE_CPU.v: default MEM data/addr widths and FETCH_BYTES for the CPU.
//  FSM state encodings local parameters in this file (IDLE/READ/DONE).
//  One sub-module: i_memory_sram_core (byte array, write-priority, registered sync read);
//   top holds FSM, counters, assembly register.
// TESTING
//  Reset: rst_n=0 -> fetch_rdy=1, instr_valid=0, instr_out=16'h0000; array preload kept.
//  Load [0]=8'hA5,[1]=8'h3C; fetch 0, BIG_ENDIAN=1 -> instr_out=16'hA53C after 3 cycles.
//  Same with BIG_ENDIAN=0 -> 16'h3CA5; hold valid 5 cycles w/o ack -> value stable, then ack -> fetch_rdy.
//  Wrap: [1023]=8'h11,[0]=8'h22; fetch 1023 -> 16'h1122.
//  Write during READ: fetch 4 ([4]=8'h01,[5]=8'h02), write [5]=8'hFF one cycle after accept
//   -> 16'h01FF, valid at cycle 4 (one stall).
//  rst_n pulse mid-READ -> instr_valid never asserts, fetch_rdy=1; subsequent fetch correct.

Source files
------------

// File: rtl/i_memory_fetch_pkg.sv
// Shared defaults, FSM encoding and slot-placement helper for the instruction fetch block.
package i_memory_fetch_pkg;

  localparam int unsigned MEM_DATA_WIDTH  = 8;
  localparam int unsigned MEM_ADDR_WIDTH  = 10;
  localparam int unsigned CPU_FETCH_BYTES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  // LSB position of byte slot k (slot 0 = byte at the base address) inside the word.
  function automatic int unsigned slot_lsb(input int unsigned k, input int unsigned nbytes,
                                           input int unsigned dw, input bit big_endian);
    return big_endian ? (nbytes - 1 - k) * dw : k * dw;
  endfunction

endpackage

// File: rtl/i_memory_sram_core.sv
// Single-port byte array: write has priority, read data registered and held between reads.
module i_memory_sram_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Array storage; deliberately not reset so loaded contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // A write cycle suppresses the read; otherwise the last read value is held.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en && !wr_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/i_memory_fetch.sv
// Instruction memory with a multi-byte fetch engine assembling FETCH_BYTES bytes per request.
module i_memory_fetch
  import i_memory_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int unsigned FETCH_BYTES = CPU_FETCH_BYTES,
  parameter int unsigned BIG_ENDIAN  = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              fetch_req,
  input  logic [ADDR_WIDTH-1:0]             fetch_addr,
  output logic                              fetch_rdy,
  output logic                              instr_valid,
  input  logic                              instr_ack,
  output logic [DATA_WIDTH*FETCH_BYTES-1:0] instr_out
);

  localparam int unsigned IW    = DATA_WIDTH * FETCH_BYTES;
  localparam int unsigned CNT_W = $clog2(FETCH_BYTES + 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      cap_cnt_q, cap_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [IW-1:0]         instr_q, instr_d;
  logic                  fetch_rdy_q, fetch_rdy_d;
  logic                  instr_valid_q, instr_valid_d;

  logic                  rd_en_c;
  logic [ADDR_WIDTH-1:0] rd_addr_c;
  logic [DATA_WIDTH-1:0] rd_data;

  i_memory_sram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en_c),
    .rd_addr (rd_addr_c),
    .rd_data (rd_data)
  );

  // Next-state: issue/capture pipeline, whole engine stalls for one cycle on any loader write.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    rd_pend_d   = rd_pend_q;
    instr_d     = instr_q;
    rd_en_c     = 1'b0;
    rd_addr_c   = base_q + ADDR_WIDTH'(issue_cnt_q);

    case (state_q)
      ST_IDLE: begin
        if (fetch_req && fetch_rdy_q) begin
          state_d     = ST_READ;
          base_d      = fetch_addr;
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
          rd_pend_d   = 1'b0;
          instr_d     = '0;
        end
      end
      ST_READ: begin
        if (!wr_en) begin
          rd_pend_d = 1'b0;
          if (rd_pend_q) begin
            for (int unsigned k = 0; k < FETCH_BYTES; k++) begin
              if (cap_cnt_q == CNT_W'(k)) begin
                instr_d[slot_lsb(k, FETCH_BYTES, DATA_WIDTH, BIG_ENDIAN != 0) +: DATA_WIDTH] = rd_data;
              end
            end
            cap_cnt_d = cap_cnt_q + CNT_W'(1);
            if (cap_cnt_q == CNT_W'(FETCH_BYTES - 1)) begin
              state_d = ST_DONE;
            end
          end
          if (issue_cnt_q < CNT_W'(FETCH_BYTES)) begin
            rd_en_c     = 1'b1;
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
            rd_pend_d   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (instr_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    fetch_rdy_d   = (state_d == ST_IDLE);
    instr_valid_d = (state_d == ST_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      issue_cnt_q   <= '0;
      cap_cnt_q     <= '0;
      rd_pend_q     <= 1'b0;
      instr_q       <= '0;
      fetch_rdy_q   <= 1'b1;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      issue_cnt_q   <= issue_cnt_d;
      cap_cnt_q     <= cap_cnt_d;
      rd_pend_q     <= rd_pend_d;
      instr_q       <= instr_d;
      fetch_rdy_q   <= fetch_rdy_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign fetch_rdy   = fetch_rdy_q;
  assign instr_valid = instr_valid_q;
  assign instr_out   = instr_q;

endmodule

// File: tb/tb_i_memory_fetch.sv
// Bench for i_memory_fetch: big- and little-endian instances share one stimulus stream.
module tb_i_memory_fetch;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        fetch_req;
  logic [9:0]  fetch_addr;
  logic        instr_ack;
  logic        be_rdy, be_valid, le_rdy, le_valid;
  logic [15:0] be_out, le_out;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] be;
    logic [15:0] le;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [9:0]  addr;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] exp_be;
    logic [15:0] exp_le;
  } vec_t;
  vec_t vecs[6];

  i_memory_fetch #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .FETCH_BYTES(2), .BIG_ENDIAN(1)) dut_be (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_rdy(be_rdy),
    .instr_valid(be_valid), .instr_ack(instr_ack), .instr_out(be_out)
  );

  i_memory_fetch #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .FETCH_BYTES(2), .BIG_ENDIAN(0)) dut_le (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_rdy(le_rdy),
    .instr_valid(le_valid), .instr_ack(instr_ack), .instr_out(le_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=running exp=done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [9:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Wait for idle, present one request for exactly one accept edge.
  task automatic fetch_accept(input logic [9:0] a, input bit push, input logic [15:0] eb,
                              input logic [15:0] el);
    int n = 0;
    while (!(be_rdy && le_rdy) && n < 20) begin
      tick();
      n++;
    end
    check("rdy_before_req", 32'(be_rdy && le_rdy), 32'd1);
    fetch_req  = 1'b1;
    fetch_addr = a;
    if (push) sb_q.push_back({eb, el});
    tick();
    fetch_req = 1'b0;
    check("rdy_low_after_accept", 32'(be_rdy), 32'd0);
  endtask

  // Count edges since accept until valid, then pop and compare the assembled words.
  task automatic wait_valid(input int exp_lat, input int already);
    int   n = already;
    exp_t e;
    while (!(be_valid && le_valid) && n < 30) begin
      tick();
      n++;
    end
    check("valid_latency", 32'(n), 32'(exp_lat));
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("word_big_endian", 32'(be_out), 32'(e.be));
      check("word_little_endian", 32'(le_out), 32'(e.le));
    end
  endtask

  task automatic ack_word();
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    check("rdy_after_ack", 32'(be_rdy && le_rdy), 32'd1);
    check("valid_clear_after_ack", 32'(be_valid || le_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{10'd0,    8'hA5, 8'h3C, 16'hA53C, 16'h3CA5};
    vecs[1] = '{10'd1023, 8'h11, 8'h22, 16'h1122, 16'h2211};
    vecs[2] = '{10'd4,    8'h01, 8'h02, 16'h0102, 16'h0201};
    vecs[3] = '{10'd511,  8'hFF, 8'h00, 16'hFF00, 16'h00FF};
    vecs[4] = '{10'd100,  8'h5A, 8'hC3, 16'h5AC3, 16'hC35A};
    vecs[5] = '{10'd1022, 8'h7E, 8'h81, 16'h7E81, 16'h817E};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    fetch_req = 1'b0; fetch_addr = '0; instr_ack = 1'b0;
    #12;
    check("reset_rdy", 32'(be_rdy && le_rdy), 32'd1);
    check("reset_valid", 32'(be_valid || le_valid), 32'd0);
    check("reset_out_be", 32'(be_out), 32'h0);
    check("reset_out_le", 32'(le_out), 32'h0);
    #1 rst_n = 1'b1;
    tick();

    // Table: load two bytes (second wraps via 10-bit add), fetch, expect 3-cycle latency.
    for (int i = 0; i < 6; i++) begin
      write_byte(vecs[i].addr, vecs[i].b0);
      write_byte(10'(vecs[i].addr + 10'd1), vecs[i].b1);
      fetch_accept(vecs[i].addr, 1'b1, vecs[i].exp_be, vecs[i].exp_le);
      wait_valid(3, 0);
      ack_word();
    end

    // Hold in DONE without ack; ignored request and a write to the base byte must not disturb.
    write_byte(10'd200, 8'hA5);
    write_byte(10'd201, 8'h3C);
    fetch_accept(10'd200, 1'b1, 16'hA53C, 16'h3CA5);
    wait_valid(3, 0);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        fetch_req  = 1'b1;
        fetch_addr = 10'd4;
      end
      if (c == 2) begin
        write_byte(10'd200, 8'h00);
      end else begin
        tick();
      end
      check("hold_valid", 32'(be_valid && le_valid), 32'd1);
      check("hold_be", 32'(be_out), 32'hA53C);
      check("hold_le", 32'(le_out), 32'h3CA5);
    end
    fetch_req = 1'b0;
    ack_word();
    for (int c = 0; c < 2; c++) begin
      tick();
      check("req_not_queued", 32'(be_rdy && !be_valid), 32'd1);
    end

    // Write to the second byte one cycle after accept: seen by the fetch, one stall.
    write_byte(10'd4, 8'h01);
    write_byte(10'd5, 8'h02);
    fetch_accept(10'd4, 1'b1, 16'h01FF, 16'hFF01);
    write_byte(10'd5, 8'hFF);
    wait_valid(4, 1);
    ack_word();

    // Write to an already-captured byte in the final capture cycle: stall, value unchanged.
    fetch_accept(10'd100, 1'b1, 16'h5AC3, 16'hC35A);
    tick();
    tick();
    write_byte(10'd100, 8'h00);
    wait_valid(4, 3);
    ack_word();

    // Reset pulse mid-READ aborts; array contents survive.
    fetch_accept(10'd4, 1'b0, 16'h0, 16'h0);
    tick();
    rst_n = 1'b0;
    #2;
    check("midreset_rdy", 32'(be_rdy && le_rdy), 32'd1);
    check("midreset_valid", 32'(be_valid || le_valid), 32'd0);
    check("midreset_out", 32'({be_out, le_out}), 32'h0);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("no_valid_after_abort", 32'(be_valid || le_valid), 32'd0);
    end
    fetch_accept(10'd4, 1'b1, 16'h01FF, 16'hFF01);
    wait_valid(3, 0);
    ack_word();

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
